// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter between the in-order pipeline writeback and
// a small FIFO of multi-cycle results (mul/div/load-miss), with a per-register
// pending scoreboard.
// Optional feature: define WB_STARVE_GUARD_EN to compile in the starvation
// guard. The guard periodically stalls the pipeline for one cycle so that a
// queued multi-cycle result cannot be blocked forever.
module wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_adr,
    input  logic [31:0] pipe_data,
    input  logic        mc_valid,
    input  logic [4:0]  mc_adr,
    input  logic [31:0] mc_data,
    output logic        mc_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_adr,
    output logic [31:0] busy,
    output logic        wb_en,
    output logic [4:0]  wb_adr,
    output logic [31:0] wb_data,
    output logic        pipe_stall
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
    // A malformed configuration never accepts multi-cycle results.
    localparam bit PARAMS_OK = (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0)
                               && (STARVE_LIMIT >= 1);

    typedef struct packed {
        logic [4:0]  adr;
        logic [31:0] data;
    } mc_entry_t;

    mc_entry_t     fifo_mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;

    mc_entry_t   head;
    logic        fifo_empty;
    logic        push;
    logic        pipe_accept;
    logic        pipe_win;
    logic        head_pop;
    logic        head_write;
    logic [31:0] busy_next;

    assign head        = fifo_mem[rd_ptr];
    assign fifo_empty  = (count == '0);
    assign mc_ready    = PARAMS_OK && (count < FULL_COUNT);
    assign push        = mc_valid && mc_ready;
    assign pipe_accept = pipe_valid && !pipe_stall;
    // A pipeline result only claims the write slot when it targets a real register.
    assign pipe_win    = pipe_accept && (pipe_adr != 5'd0);
    // An x0 head needs no write slot, so it is discarded even while the pipeline writes.
    assign head_pop    = !fifo_empty && (!pipe_win || (head.adr == 5'd0));
    assign head_write  = head_pop && (head.adr != 5'd0);

    // FIFO payload storage.
    // NOTE: the storage array has no reset; emptiness is defined by count, so
    // stale payload is never observed and the array maps onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_mem[wr_ptr] <= '{adr: mc_adr, data: mc_data};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (head_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, head_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Registered write port: pipeline first, then the FIFO head.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en   <= 1'b0;
            wb_adr  <= 5'd0;
            wb_data <= 32'd0;
        end else if (pipe_win) begin
            wb_en   <= 1'b1;
            wb_adr  <= pipe_adr;
            wb_data <= pipe_data;
        end else if (head_write) begin
            wb_en   <= 1'b1;
            wb_adr  <= head.adr;
            wb_data <= head.data;
        end else begin
            wb_en   <= 1'b0;
        end
    end

    // Scoreboard update: clear on FIFO retire, then set on issue so set wins.
    // NOTE: give every always_comb output a default first; a missed branch
    // would otherwise infer a latch.
    always_comb begin
        busy_next = busy;
        if (head_pop) begin
            busy_next[head.adr] = 1'b0;
        end
        if (issue_valid && (issue_adr != 5'd0)) begin
            busy_next[issue_adr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

`ifdef WB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_cnt;
    logic          stall_q;

    // Count consecutive blocked-head cycles; stall the pipeline once on reaching the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            stall_q    <= 1'b0;
        end else if (fifo_empty || head_pop) begin
            starve_cnt <= '0;
            stall_q    <= 1'b0;
        end else if (starve_cnt == CW'(STARVE_LIMIT - 1)) begin
            starve_cnt <= CW'(STARVE_LIMIT);
            stall_q    <= 1'b1;
        end else begin
            starve_cnt <= starve_cnt + 1'b1;
            stall_q    <= 1'b0;
        end
    end

    assign pipe_stall = stall_q;
`else
    assign pipe_stall = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_wb_arbiter;

    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_valid;
    logic [4:0]  pipe_adr;
    logic [31:0] pipe_data;
    logic        mc_valid;
    logic [4:0]  mc_adr;
    logic [31:0] mc_data;
    logic        mc_ready;
    logic        issue_valid;
    logic [4:0]  issue_adr;
    logic [31:0] busy;
    logic        wb_en;
    logic [4:0]  wb_adr;
    logic [31:0] wb_data;
    logic        pipe_stall;

    wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk         (clk),
        .rst         (rst),
        .pipe_valid  (pipe_valid),
        .pipe_adr    (pipe_adr),
        .pipe_data   (pipe_data),
        .mc_valid    (mc_valid),
        .mc_adr      (mc_adr),
        .mc_data     (mc_data),
        .mc_ready    (mc_ready),
        .issue_valid (issue_valid),
        .issue_adr   (issue_adr),
        .busy        (busy),
        .wb_en       (wb_en),
        .wb_adr      (wb_adr),
        .wb_data     (wb_data),
        .pipe_stall  (pipe_stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  adr;
        logic [31:0] data;
    } ent_t;

    // Reference model state.
    ent_t        mq[$];
    logic [31:0] m_busy  = '0;
    logic        m_en    = 1'b0;
    logic [4:0]  m_adr   = '0;
    logic [31:0] m_data  = '0;
    logic        m_stall = 1'b0;
    int          m_blk   = 0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md,
                         input logic iv, input logic [4:0] ia);
        pipe_valid  = pv;
        pipe_adr    = pa;
        pipe_data   = pd;
        mc_valid    = mv;
        mc_adr      = ma;
        mc_data     = md;
        issue_valid = iv;
        issue_adr   = ia;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    endtask

    // Advance the model by one cycle from the current inputs, clock the DUT, compare.
    task automatic step();
        ent_t h;
        bit   ready;
        bit   pwin;
        bit   pop;
        bit   nstall;
        ready  = (mq.size() < DEPTH);
        nstall = 1'b0;
        if (rst) begin
            mq.delete();
            m_busy = '0;
            m_en   = 1'b0;
            m_adr  = '0;
            m_data = '0;
            m_blk  = 0;
        end else begin
            pwin = pipe_valid && !m_stall && (pipe_adr != 5'd0);
            pop  = (mq.size() > 0) && (!pwin || (mq[0].adr == 5'd0));
            h    = pop ? mq[0] : '0;
            m_en = 1'b0;
            if (pwin) begin
                m_en   = 1'b1;
                m_adr  = pipe_adr;
                m_data = pipe_data;
            end else if (pop && (h.adr != 5'd0)) begin
                m_en   = 1'b1;
                m_adr  = h.adr;
                m_data = h.data;
            end
            if (pop) m_busy[h.adr] = 1'b0;
            if (issue_valid && (issue_adr != 5'd0)) m_busy[issue_adr] = 1'b1;
            m_busy[0] = 1'b0;
`ifdef WB_STARVE_GUARD_EN
            if ((mq.size() > 0) && !pop) m_blk++;
            else m_blk = 0;
            nstall = (m_blk == STARVE_LIMIT);
`endif
            if (pop) void'(mq.pop_front());
            if (mc_valid && ready) begin
                h.adr  = mc_adr;
                h.data = mc_data;
                mq.push_back(h);
            end
        end
        m_stall = nstall;
        @(posedge clk);
        #1;
        check("wb_en", {31'd0, wb_en}, {31'd0, m_en});
        if (m_en || rst) begin
            check("wb_adr", {27'd0, wb_adr}, {27'd0, m_adr});
            check("wb_data", wb_data, m_data);
        end
        check("busy", busy, m_busy);
        check("mc_ready", {31'd0, mc_ready}, {31'd0, (mq.size() < DEPTH)});
        check("pipe_stall", {31'd0, pipe_stall}, {31'd0, m_stall});
    endtask

    initial begin
        idle();
        rst = 1'b1;
        // Reset held for two cycles.
        step();
        step();
        check("rst_wb_en", {31'd0, wb_en}, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_mc_ready", {31'd0, mc_ready}, 32'd1);
        check("rst_pipe_stall", {31'd0, pipe_stall}, 32'd0);
        rst = 1'b0;

        // Pipeline write, then a dropped x0 pipeline write.
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        step();
        check("pipe_wr_en", {31'd0, wb_en}, 32'd1);
        check("pipe_wr_adr", {27'd0, wb_adr}, 32'd5);
        check("pipe_wr_data", wb_data, 32'hDEADBEEF);
        drive(1'b1, 5'd0, 32'h11111111, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        step();
        check("pipe_x0_en", {31'd0, wb_en}, 32'd0);

        // Issue x7, result returns three cycles later, written two cycles after that.
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
        step();
        check("busy7_set", {31'd0, busy[7]}, 32'd1);
        idle();
        step();
        step();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h12, 1'b0, 5'd0);
        step();
        idle();
        step();
        check("mc7_en", {31'd0, wb_en}, 32'd1);
        check("mc7_adr", {27'd0, wb_adr}, 32'd7);
        check("busy7_clr", {31'd0, busy[7]}, 32'd0);

        // Pipeline holds the port while the FIFO fills, then the FIFO drains in order.
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd8, 32'h88, 1'b0, 5'd0);
        step();
        drive(1'b1, 5'd3, 32'h34, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0);
        step();
        check("full_ready", {31'd0, mc_ready}, 32'd0);
        drive(1'b1, 5'd3, 32'h35, 1'b1, 5'd10, 32'hAA, 1'b0, 5'd0);
        step();
        idle();
        step();
        check("drain0_adr", {27'd0, wb_adr}, 32'd8);
        step();
        check("drain1_adr", {27'd0, wb_adr}, 32'd9);
        check("drain_ready", {31'd0, mc_ready}, 32'd1);
        step();
        check("drain_done_en", {31'd0, wb_en}, 32'd0);

        // Issue to a register in the same cycle its FIFO head retires: set wins.
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd4);
        step();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4);
        step();
        check("busy4_set_wins", {31'd0, busy[4]}, 32'd1);
        idle();
        step();

        // x0 entry in the FIFO is discarded while the pipeline writes.
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55, 1'b0, 5'd0);
        step();
        drive(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        step();
        idle();
        step();

        // Reset while results are queued loses them.
        drive(1'b1, 5'd3, 32'h1, 1'b1, 5'd11, 32'hB1, 1'b1, 5'd11);
        step();
        drive(1'b1, 5'd3, 32'h2, 1'b1, 5'd12, 32'hB2, 1'b1, 5'd12);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        step();
        check("post_rst_en", {31'd0, wb_en}, 32'd0);
        check("post_rst_busy", busy, 32'd0);

`ifdef WB_STARVE_GUARD_EN
        // Pipeline monopolises the port; the guard forces the queued entry out.
        drive(1'b1, 5'd3, 32'h300, 1'b1, 5'd13, 32'hD13, 1'b0, 5'd0);
        step();
        for (int i = 0; i < STARVE_LIMIT + 3; i++) begin
            drive(1'b1, 5'd3, 32'h301 + i, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
            step();
        end
        idle();
        step();
`endif

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive(($urandom_range(0, 99) < 55),
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                  $urandom(),
                  ($urandom_range(0, 99) < 40),
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                  $urandom(),
                  ($urandom_range(0, 99) < 30),
                  5'($urandom_range(0, 31)));
            step();
        end
        rst = 1'b0;
        idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
